mul_div_unit: RTL and testbench

//  Multi-cycle MIPS HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mul_div_unit.sv | 135 +++++++++++++
 tb/tb_mul_div_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, iteration
// count, FSM states and the conditional-negate helpers used on entry and exit.
package mdu_pkg;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic [31:0] mdu_cneg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] mdu_cneg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO unit: one shift-add or restoring-divide step per clock,
// 32 steps per operation, with sign handling applied on magnitudes at entry/exit.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state_reg, state_next;
  mdu_op_e    op_reg;
  logic [4:0]  count_reg;
  logic [63:0] acc_reg;
  logic [31:0] opb_reg;
  logic [31:0] rs_reg;
  logic        neg_q_reg, neg_r_reg, div_zero_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        launch, last, is_div, signed_in;
  logic [32:0] mul_sum, rem_shift, div_diff;
  logic        div_ok;
  logic [63:0] step_acc, prod;
  logic [31:0] res_hi, res_lo;

  assign launch    = (state_reg == IDLE) && start;
  assign last      = (state_reg == RUN) && (count_reg == 5'(MDU_ITERS - 1));
  assign is_div    = (op_reg == MDU_DIV) || (op_reg == MDU_DIVU);
  assign signed_in = (op == MDU_MULT) || (op == MDU_DIV);

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
  assign mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  assign rem_shift = {acc_reg[63:32], acc_reg[31]};
  assign div_diff  = rem_shift - {1'b0, opb_reg};
  assign div_ok    = ~div_diff[32];

  always_comb begin
    step_acc = {mul_sum, acc_reg[31:1]};
    if (is_div) begin
      step_acc = {(div_ok ? div_diff[31:0] : rem_shift[31:0]), acc_reg[30:0], div_ok};
    end
  end

  // Final fix-up applied to the result of the last iteration.
  always_comb begin
    prod   = mdu_cneg64(step_acc, neg_q_reg);
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      if (div_zero_reg) begin
        res_hi = rs_reg;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = mdu_cneg32(step_acc[63:32], neg_r_reg);
        res_lo = mdu_cneg32(step_acc[31:0], neg_q_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg       <= MDU_MULT;
      count_reg    <= 5'd0;
      acc_reg      <= 64'd0;
      opb_reg      <= 32'd0;
      rs_reg       <= 32'd0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (launch) begin
        op_reg       <= mdu_op_e'(op);
        count_reg    <= 5'd0;
        acc_reg      <= {32'd0, mdu_cneg32(rs_data, signed_in && rs_data[31])};
        opb_reg      <= mdu_cneg32(rt_data, signed_in && rt_data[31]);
        rs_reg       <= rs_data;
        neg_q_reg    <= signed_in && (rs_data[31] ^ rt_data[31]);
        neg_r_reg    <= signed_in && rs_data[31];
        div_zero_reg <= op[1] && (rt_data == 32'd0);
      end else if (state_reg == RUN) begin
        acc_reg   <= step_acc;
        count_reg <= count_reg + 5'd1;
        if (last) begin
          hi_reg   <= res_hi;
          lo_reg   <= res_lo;
          done_reg <= 1'b1;
        end
      end else begin
        // Moves only land in IDLE without a competing start.
        if (mthi) hi_reg <= rs_data;
        if (mtlo) lo_reg <= rs_data;
      end
    end
  end

  assign busy  = (state_reg == RUN);
  assign done  = done_reg;
  assign stall = mf_req && busy;
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, reset, conflicts, stall.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, mf_req;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .mf_req(mf_req),
    .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle c0 of a run; returns at the done cycle (or the bound).
  task automatic wait_done(input int c0, output int lat, output int nbusy, output int nstall);
    lat = c0; nbusy = 0; nstall = 0;
    while (!done && lat < 40) begin
      if (busy)  nbusy++;
      if (stall) nstall++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int nbusy);
    int ns;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, nbusy, ns);
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h lat=%0d", o, a, b, hi, lo, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nb, ns, ndone;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;

    // 1. MULTU max*max, latency and busy width
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
    check("multu_lat", lat, 33);
    check("multu_busy", nb, 32);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // 2. signed multiply and divides
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, nb);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, nb);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd7, 32'd2, lat, nb);
    check("divu_lo", lo, 3);
    check("divu_hi", hi, 1);

    // 3. overflow and divide-by-zero
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
    check("divovf_lat", lat, 33);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 0);
    do_op(2'b11, 32'd5, 32'd0, lat, nb);
    check("divz_lat", lat, 33);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 5);

    // 4. reset in cycle 10 of RUN
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    ndone = 0;
    for (int i = 0; i < 35; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_nodone", ndone, 0);
    $display("reset mid-run: busy=%b hi=%h lo=%h done pulses=%0d", busy, hi, lo, ndone);
    do_op(2'b01, 32'd3, 32'd4, lat, nb);
    check("after_rst_lo", lo, 12);
    check("after_rst_hi", hi, 0);

    // 5. start and mthi while busy are dropped
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0; mthi = 1'b1; rs_data = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    wait_done(6, lat, nb, ns);
    $display("busy-conflict op: hi=%h lo=%h lat=%0d", hi, lo, lat);
    check("busyconf_lat", lat, 33);
    check("busyconf_lo", lo, 14);
    check("busyconf_hi", hi, 2);
    @(negedge clk);
    mthi = 1'b1; rs_data = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    $display("mthi idle: hi=%h lo=%h done=%b", hi, lo, done);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 14);
    check("mthi_nodone", done, 0);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hABCD;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", hi, 32'hABCD);
    check("mthilo_lo", lo, 32'hABCD);
    start = 1'b1; mtlo = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd6;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("startwins_lo", lo, 32'hABCD);
    wait_done(1, lat, nb, ns);
    check("startwins_res", lo, 30);

    // 6. stall behaviour and back-to-back start in the done cycle
    @(negedge clk);
    mf_req = 1'b1;
    @(negedge clk);
    check("stall_idle", stall, 0);
    start = 1'b1; op = 2'b01; rs_data = 32'd11; rt_data = 32'd13;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, nb, ns);
    $display("stall run: hi=%h lo=%h lat=%0d stall cycles=%0d", hi, lo, lat, ns);
    check("stall_cycles", ns, 32);
    check("stall_at_done", stall, 0);
    check("b2b_first_lo", lo, 143);
    start = 1'b1; op = 2'b01; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(1, lat, nb, ns);
    $display("back-to-back: hi=%h lo=%h lat=%0d", hi, lo, lat);
    check("b2b_lat", lat, 33);
    check("b2b_lo", lo, 42);
    mf_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
